// File: rtl/ram_seq_pkg.sv
// rtl/ram_seq_pkg.sv - shared types and constants for the RAM byte-access sequencer
package ram_seq_pkg;
   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_ILL = 2'b11
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_LAST,
      WR,
      RESP
   } seq_state_t;

   localparam int RAM_DEPTH  = 1536;
   localparam int BANK_BYTES = 512;

   // Byte count of an access; the illegal size reports 1 so range math stays harmless.
   function automatic logic [2:0] size_bytes(input mem_size_t sz);
      case (sz)
         SZ_H:    return 3'd2;
         SZ_W:    return 3'd4;
         default: return 3'd1;
      endcase
   endfunction
endpackage

// File: rtl/ram_byte_access_seq_if.sv
// rtl/ram_byte_access_seq_if.sv - CPU request/response and byte-RAM port bundle
interface ram_byte_access_seq_if #(
   parameter int ADDR_W = 11
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_uns;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_raddr;
   logic [7:0]        ram_rdata;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [7:0]        ram_wdata;

   modport master (
      output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, ram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, ram_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata
   );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of assembled load data
module load_extend
   import ram_seq_pkg::*;
(
   input  logic [31:0] raw,
   input  mem_size_t   size,
   input  logic        uns,
   output logic [31:0] ext
);
   always_comb begin
      ext = raw;
      case (size)
         SZ_B:    ext = {{24{raw[7] & ~uns}}, raw[7:0]};
         SZ_H:    ext = {{16{raw[15] & ~uns}}, raw[15:0]};
         default: ext = raw;
      endcase
   end
endmodule

// File: rtl/ram_byte_access_seq.sv
// rtl/ram_byte_access_seq.sv - sequences CPU 8/16/32-bit loads/stores into byte RAM accesses
// Optional: MISALIGNED_ACCESS_EN makes unaligned half/word legal (loads run 2 cycles per byte).
module ram_byte_access_seq #(
   parameter int ADDR_W    = 11,
   parameter int RAM_DEPTH = ram_seq_pkg::RAM_DEPTH
) (
   input logic                  clk,
   input logic                  rst_n,
   ram_byte_access_seq_if.slave bus
);
   import ram_seq_pkg::*;

`ifdef MISALIGNED_ACCESS_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   seq_state_t        state, state_nx;
   logic [1:0]        cnt, last_idx, cap_idx;
   logic              cnt_inc, cap_en, phase, phase_nx;
   logic [ADDR_W-1:0] base;
   logic              we_r, uns_r, err_r, mis_r;
   mem_size_t         size_r;
   logic [31:0]       wdata_r, data_r, ext_data;

   mem_size_t         req_sz;
   logic [2:0]        req_n;
   logic [ADDR_W:0]   req_end;
   logic              req_mis, req_oor, req_err, accept;

   always_comb begin
      req_sz  = mem_size_t'(bus.req_size);
      req_n   = size_bytes(req_sz);
      req_mis = (req_sz == SZ_H && bus.req_addr[0]) ||
                (req_sz == SZ_W && bus.req_addr[1:0] != 2'b00);
      req_end = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_n - 3'd1);
      req_oor = req_end >= (ADDR_W+1)'(RAM_DEPTH);
      req_err = (req_sz == SZ_ILL) || req_oor || (req_mis && !MIS_EN);
      accept  = bus.req_valid && (state == IDLE);
   end

   load_extend u_load_extend (
      .raw  (data_r),
      .size (size_r),
      .uns  (uns_r),
      .ext  (ext_data)
   );

   always_comb begin
      state_nx      = state;
      cnt_inc       = 1'b0;
      cap_en        = 1'b0;
      cap_idx       = cnt;
      phase_nx      = phase;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_err   = 1'b0;
      bus.ram_re    = 1'b0;
      bus.ram_raddr = '0;
      bus.ram_we    = 1'b0;
      bus.ram_waddr = '0;
      bus.ram_wdata = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_nx = req_err ? RESP : (bus.req_we ? WR : RD);
         end
         RD: begin
            bus.ram_re    = 1'b1;
            bus.ram_raddr = base + ADDR_W'(cnt);
            if (mis_r) begin
               // Unpipelined: issue on phase 0, capture with the address held on phase 1.
               if (phase) begin
                  cap_en = 1'b1;
                  if (cnt == last_idx) state_nx = RESP;
                  else                 cnt_inc  = 1'b1;
               end
               phase_nx = ~phase;
            end else begin
               if (cnt != 2'd0) begin
                  cap_en  = 1'b1;
                  cap_idx = cnt - 2'd1;
               end
               if (cnt == last_idx) state_nx = RD_LAST;
               else                 cnt_inc  = 1'b1;
            end
         end
         RD_LAST: begin
            bus.ram_re    = 1'b1;
            bus.ram_raddr = base + ADDR_W'(last_idx);
            cap_en        = 1'b1;
            cap_idx       = last_idx;
            state_nx      = RESP;
         end
         WR: begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = base + ADDR_W'(cnt);
            bus.ram_wdata = wdata_r[{cnt, 3'b000} +: 8];
            if (cnt == last_idx) state_nx = RESP;
            else                 cnt_inc  = 1'b1;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_r;
            bus.rsp_rdata = (err_r || we_r) ? 32'h0 : ext_data;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         last_idx <= 2'd0;
         phase    <= 1'b0;
         base     <= '0;
         we_r     <= 1'b0;
         uns_r    <= 1'b0;
         err_r    <= 1'b0;
         mis_r    <= 1'b0;
         size_r   <= SZ_B;
         wdata_r  <= 32'h0;
         data_r   <= 32'h0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt      <= 2'd0;
            last_idx <= 2'(req_n - 3'd1);
            phase    <= 1'b0;
            base     <= bus.req_addr;
            we_r     <= bus.req_we;
            uns_r    <= bus.req_uns;
            err_r    <= req_err;
            mis_r    <= req_mis && MIS_EN;
            size_r   <= req_sz;
            wdata_r  <= bus.req_wdata;
            data_r   <= 32'h0;
         end else begin
            phase <= phase_nx;
            if (cnt_inc) cnt <= cnt + 2'd1;
            if (cap_en)  data_r[{cap_idx, 3'b000} +: 8] <= bus.ram_rdata;
         end
      end
   end
endmodule

// File: tb/tb_ram_byte_access_seq.sv
// tb/tb_ram_byte_access_seq.sv - scoreboard bench for ram_byte_access_seq
module tb_ram_byte_access_seq;
   import ram_seq_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [10:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   last_rsp_cyc = -10;
   bit   both_seen = 1'b0;
   bit   mem_ready = 1'b0;

   logic [7:0]  ref_mem [RAM_DEPTH];
   logic [7:0]  mem     [RAM_DEPTH];
   rsp_t        sb[$];
   wr_t         exp_w[$];
   logic [10:0] exp_r[$];

   ram_byte_access_seq_if bus ();

   ram_byte_access_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 13 + 5);
   endfunction

   // Byte RAM model: registered read data, valid the cycle after issue.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (bus.ram_we && int'(bus.ram_waddr) < RAM_DEPTH) begin
         mem[bus.ram_waddr] <= bus.ram_wdata;
      end
      if (bus.ram_re && int'(bus.ram_raddr) < RAM_DEPTH)
         bus.ram_rdata <= mem[bus.ram_raddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to the next falling edge and score whatever the DUT shows there.
   task automatic tick();
      rsp_t r;
      wr_t  w;
      @(negedge clk);
      if (rst_n) begin
         if (bus.ram_re && bus.ram_we) both_seen = 1'b1;
         if (bus.ram_we) begin
            check("we_expected", 32'(exp_w.size() != 0), 1);
            if (exp_w.size() != 0) begin
               w = exp_w.pop_front();
               check("waddr", 32'(bus.ram_waddr), 32'(w.addr));
               check("wdata", 32'(bus.ram_wdata), 32'(w.data));
            end
         end
         if (bus.ram_re) begin
            check("re_expected", 32'(exp_r.size() != 0), 1);
            if (exp_r.size() != 0) check("raddr", 32'(bus.ram_raddr), 32'(exp_r.pop_front()));
         end
         if (bus.rsp_valid) begin
            check("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               r = sb.pop_front();
               check("rsp_rdata", bus.rsp_rdata, r.rdata);
               check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
               check("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
            end
            last_rsp_cyc = cyc;
         end
      end
   endtask

   task automatic send(input logic w, input logic [1:0] sz, input logic u,
                       input logic [10:0] addr, input logic [31:0] wd, input logic b2b);
      int          n, t;
      bit          err, mis;
      logic [31:0] raw, exp;
      rsp_t        r;
      wr_t         e;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = (int'(addr) % n) != 0;
      err = (sz == 2'd3) || (int'(addr) + n - 1 >= RAM_DEPTH);
`ifndef MISALIGNED_ACCESS_EN
      err = err || mis;
`endif
      raw = 32'h0;
      if (!err) for (int k = 0; k < n; k++) raw[8*k +: 8] = ref_mem[int'(addr) + k];
      case (sz)
         2'd0:    exp = u ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'd1:    exp = u ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: exp = raw;
      endcase
      if (err || w) exp = 32'h0;

      tick();
      bus.req_valid = 1'b1;
      bus.req_we    = w;
      bus.req_size  = sz;
      bus.req_uns   = u;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      t = 0;
      while (!bus.req_ready && t < 100) begin
         tick();
         t++;
      end
      check("accept_in_time", 32'(t < 100), 1);
      if (b2b) check("b2b_gap", 32'(cyc - last_rsp_cyc), 1);

      r.rdata = exp;
      r.err   = err;
      r.acc   = cyc;
      r.lat   = err ? 1 : w ? n + 1 : mis ? 2 * n + 1 : n + 2;
      sb.push_back(r);
      if (!err) begin
         for (int k = 0; k < n; k++) begin
            if (w) begin
               e.addr = 11'(int'(addr) + k);
               e.data = wd[8*k +: 8];
               exp_w.push_back(e);
               ref_mem[int'(addr) + k] = wd[8*k +: 8];
            end else begin
               exp_r.push_back(11'(int'(addr) + k));
               if (mis) exp_r.push_back(11'(int'(addr) + k));
            end
         end
         if (!w && !mis) exp_r.push_back(11'(int'(addr) + n - 1));
      end
      tick();
      check("ready_busy", 32'(bus.req_ready), 0);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      bus.req_valid = 1'b0;
      bus.req_addr  = 11'($urandom);
      bus.req_wdata = $urandom;
      while ((sb.size() != 0 || !bus.req_ready) && t < 100) begin
         tick();
         t++;
      end
      check("drain_in_time", 32'(t < 100), 1);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [10:0] addr;
      wr_t         e;
      for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = pat(i);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'd0;
      bus.req_uns   = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      repeat (3) tick();
      check("rst_req_ready", 32'(bus.req_ready), 1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_rsp_err", 32'(bus.rsp_err), 0);
      check("rst_ram_re", 32'(bus.ram_re), 0);
      check("rst_ram_we", 32'(bus.ram_we), 0);
      check("rst_ram_raddr", 32'(bus.ram_raddr), 0);
      check("rst_ram_waddr", 32'(bus.ram_waddr), 0);
      check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
      rst_n = 1'b1;
      tick();

      // Word store then load at 0x004.
      send(1'b1, 2'd2, 1'b0, 11'h004, 32'hDEADBEEF, 1'b0); wait_idle();
      send(1'b0, 2'd2, 1'b0, 11'h004, 32'h0, 1'b0);        wait_idle();
      // Extension across the bank boundary.
      send(1'b1, 2'd0, 1'b0, 11'(BANK_BYTES - 1), 32'h0000_0080, 1'b0); wait_idle();
      send(1'b1, 2'd1, 1'b0, 11'(BANK_BYTES), 32'h0000_8001, 1'b0);     wait_idle();
      send(1'b0, 2'd0, 1'b0, 11'(BANK_BYTES - 1), 32'h0, 1'b0); wait_idle();
      send(1'b0, 2'd0, 1'b1, 11'(BANK_BYTES - 1), 32'h0, 1'b0); wait_idle();
      send(1'b0, 2'd1, 1'b0, 11'(BANK_BYTES), 32'h0, 1'b0);     wait_idle();
      send(1'b0, 2'd1, 1'b1, 11'(BANK_BYTES), 32'h0, 1'b0);     wait_idle();
      // Errors and range edges.
      send(1'b0, 2'd2, 1'b0, 11'h002, 32'h0, 1'b0);          wait_idle();
      send(1'b1, 2'd1, 1'b0, 11'h5FF, 32'hFFFF, 1'b0);       wait_idle();
      send(1'b0, 2'd3, 1'b0, 11'h010, 32'h0, 1'b0);          wait_idle();
      send(1'b1, 2'd2, 1'b0, 11'h5FD, 32'h1234_5678, 1'b0);  wait_idle();
      send(1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0);          wait_idle();
      send(1'b0, 2'd2, 1'b0, 11'h5FC, 32'h0, 1'b0);          wait_idle();
      send(1'b0, 2'd0, 1'b1, 11'h5FF, 32'h0, 1'b0);          wait_idle();
      send(1'b0, 2'd2, 1'b0, 11'h1FE, 32'h0, 1'b0);          wait_idle();
      send(1'b1, 2'd1, 1'b0, 11'h101, 32'hA55A, 1'b0);       wait_idle();
      send(1'b0, 2'd2, 1'b0, 11'h100, 32'h0, 1'b0);          wait_idle();

      // Back-to-back with REQ_VALID held.
      send(1'b1, 2'd2, 1'b0, 11'h040, 32'h0BAD_CAFE, 1'b0);
      send(1'b0, 2'd2, 1'b0, 11'h040, 32'h0, 1'b1);
      send(1'b0, 2'd1, 1'b1, 11'h042, 32'h0, 1'b1);
      send(1'b0, 2'd2, 1'b0, 11'h003, 32'h0, 1'b1);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         sz   = 2'($urandom_range(0, 3));
         addr = 11'($urandom_range(0, 2047));
         if ($urandom_range(0, 3) != 0) begin
            addr = 11'($urandom_range(0, RAM_DEPTH - 1));
            if (sz == 2'd1) addr[0] = 1'b0;
            else if (sz == 2'd2) addr[1:0] = 2'b00;
         end
         send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0);
         if ($urandom_range(0, 1) == 0) wait_idle();
      end
      wait_idle();

      // Reset during the second byte of a word store.
      tick();
      check("rst_store_ready", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 11'h010;
      bus.req_wdata = 32'hCAFE_F00D;
      e.addr = 11'h010; e.data = 8'h0D; exp_w.push_back(e); ref_mem[16] = 8'h0D;
      e.addr = 11'h011; e.data = 8'hF0; exp_w.push_back(e); ref_mem[17] = 8'hF0;
      tick();
      bus.req_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      tick();
      check("abort_req_ready", 32'(bus.req_ready), 1);
      check("abort_ram_we", 32'(bus.ram_we), 0);
      check("abort_ram_waddr", 32'(bus.ram_waddr), 0);
      check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
      #2 rst_n = 1'b1;
      repeat (4) tick();
      check("abort_writes_done", 32'(exp_w.size()), 0);
      send(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 1'b0); wait_idle();

      repeat (4) tick();
      check("sb_empty", 32'(sb.size()), 0);
      check("exp_w_empty", 32'(exp_w.size()), 0);
      check("exp_r_empty", 32'(exp_r.size()), 0);
      check("re_we_exclusive", 32'(both_seen), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
